// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: reset synchroniser and staggered release sequencer.
// All N_CH reset outputs assert asynchronously on the pin reset. Release is
// synchronous: a hold period first, then one channel at a time from ch0
// (fabric) up to ch N_CH-1 (CPU core). Software and watchdog requests restart
// the sequence. The cause of the last reset is kept until the next pin reset.
module reset_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int N_CH        = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_sw_rst,
    input  logic            i_wdt_rst,
    output logic [N_CH-1:0] o_rstn,
    output logic            o_busy,
    output logic [1:0]      o_cause
);

    localparam int CNT_TOP = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int CW      = $clog2(CNT_TOP + 1);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0]   CNT_MAX  = CW'(CNT_TOP);
    localparam logic [CW-1:0]   HOLD_MAX = CW'(HOLD_CYC);
    localparam logic [CW-1:0]   STG_LAST = CW'(STAGGER_CYC - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    localparam logic [1:0] CAUSE_PIN = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [N_CH-1:0]        rstn_q, rstn_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cause_q, cause_d;

    logic          rt;
    logic          req;
    logic [CW-1:0] cnt_inc;

    assign rt      = sync_q[SYNC_STAGES-1];
    assign req     = i_sw_rst | i_wdt_rst;
    // Counters stop at their maximum instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Deassert synchroniser: shifts in a 1 once the pin reset is released.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Sequencer next-state: hold, staggered release, run; requests restart it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rstn_d  = rstn_q;
        busy_d  = busy_q;
        cause_d = cause_q;

        unique case (state_q)
            ST_HOLD: begin
                if (rt) begin
                    if (cnt_q == HOLD_MAX) begin
                        rstn_d[0] = 1'b1;
                        cnt_d     = '0;
                        if (N_CH == 1) begin
                            busy_d  = 1'b0;
                            state_d = ST_RUN;
                        end else begin
                            ch_d    = CH_W'(1);
                            state_d = ST_STAGGER;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_STAGGER: begin
                if (cnt_q == STG_LAST) begin
                    rstn_d[ch_q] = 1'b1;
                    cnt_d        = '0;
                    if (ch_q == LAST_CH) begin
                        busy_d  = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                // Outputs hold their released values.
            end
            default: begin
                rstn_d  = '0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                ch_d    = '0;
                state_d = ST_HOLD;
            end
        endcase

        // A request overrides everything: re-assert all channels and restart.
        if (req) begin
            rstn_d  = '0;
            busy_d  = 1'b1;
            cnt_d   = '0;
            ch_d    = '0;
            state_d = ST_HOLD;
            cause_d = i_wdt_rst ? CAUSE_WDT : CAUSE_SW;
        end
    end

    // State registers, all cleared asynchronously by the pin reset.
    // NOTE: the async active-low reset appears in the sensitivity list so the
    // outputs assert with no clock running.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q  <= '0;
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            ch_q    <= '0;
            rstn_q  <= '0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_PIN;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value of the others.
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign o_rstn  = rstn_q;
    assign o_busy  = busy_q;
    assign o_cause = cause_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb_reset_seq_ctrl: directed bench for reset_seq_ctrl.
// dut uses default parameters; dut6 uses N_CH=1, HOLD_CYC=1, SYNC_STAGES=3.
// Both share the pin reset; requests are driven separately.
module tb_reset_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       sw_rst, wdt_rst;
    logic [3:0] o_rstn;
    logic       busy;
    logic [1:0] cause;

    logic       sw_rst6, wdt_rst6;
    logic [0:0] o_rstn6;
    logic       busy6;
    logic [1:0] cause6;

    int total;
    int bad;
    int edge_no;

    reset_seq_ctrl dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_sw_rst  (sw_rst),
        .i_wdt_rst (wdt_rst),
        .o_rstn    (o_rstn),
        .o_busy    (busy),
        .o_cause   (cause)
    );

    reset_seq_ctrl #(
        .SYNC_STAGES (3),
        .N_CH        (1),
        .HOLD_CYC    (1),
        .STAGGER_CYC (4)
    ) dut6 (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_sw_rst  (sw_rst6),
        .i_wdt_rst (wdt_rst6),
        .o_rstn    (o_rstn6),
        .o_busy    (busy6),
        .o_cause   (cause6)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected default-DUT outputs when ch0 rises at edge s (4-cycle stagger).
    function automatic logic [3:0] exp_rstn(input int e, input int s);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e >= s + 4 * k);
        return r;
    endfunction

    function automatic logic exp_busy(input int e, input int s);
        return (e < s + 12);
    endfunction

    // Advance one rising edge and sample 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if (o_rstn !== 4'h0 || busy !== 1'b1 || cause !== 2'b00) begin
            bad++;
            $display("FAIL reset_state got rstn=%h busy=%b cause=%b want 0/1/00", o_rstn, busy, cause);
        end
        total++;
        if (o_rstn6 !== 1'b0 || busy6 !== 1'b1 || cause6 !== 2'b00) begin
            bad++;
            $display("FAIL reset_state_n1 got rstn=%h busy=%b cause=%b want 0/1/00", o_rstn6, busy6, cause6);
        end
        rstn    = 1'b1;
        edge_no = 0;
    endtask

    task automatic test_por();
        while (edge_no < 40) begin
            tick();
            total++;
            if (o_rstn !== exp_rstn(edge_no, 19) || busy !== exp_busy(edge_no, 19)) begin
                bad++;
                $display("FAIL por_seq edge=%0d got rstn=%h busy=%b want rstn=%h busy=%b",
                         edge_no, o_rstn, busy, exp_rstn(edge_no, 19), exp_busy(edge_no, 19));
            end
            total++;
            if (o_rstn6 !== 1'(edge_no >= 5) || busy6 !== 1'(edge_no < 5)) begin
                bad++;
                $display("FAIL por_n1 edge=%0d got rstn=%b busy=%b want rstn=%b busy=%b",
                         edge_no, o_rstn6, busy6, edge_no >= 5, edge_no < 5);
            end
        end
        total++;
        if (cause !== 2'b00) begin
            bad++;
            $display("FAIL por_cause got=%b want=00", cause);
        end
    endtask

    // Request pulse at edge e_req, checked until the sequence completes.
    task automatic req_pulse(input int e_req, input logic sw, input logic wdt,
                             input logic [1:0] want_cause);
        while (edge_no < e_req - 1) tick();
        sw_rst  = sw;
        wdt_rst = wdt;
        tick();
        sw_rst  = 1'b0;
        wdt_rst = 1'b0;
        total++;
        if (o_rstn !== 4'h0 || busy !== 1'b1 || cause !== want_cause) begin
            bad++;
            $display("FAIL req_assert edge=%0d got rstn=%h busy=%b cause=%b want 0/1/%b",
                     edge_no, o_rstn, busy, cause, want_cause);
        end
        while (edge_no < e_req + 35) begin
            tick();
            total++;
            if (o_rstn !== exp_rstn(edge_no, e_req + 17) || busy !== exp_busy(edge_no, e_req + 17)) begin
                bad++;
                $display("FAIL req_seq edge=%0d got rstn=%h busy=%b want rstn=%h busy=%b",
                         edge_no, o_rstn, busy, exp_rstn(edge_no, e_req + 17), exp_busy(edge_no, e_req + 17));
            end
        end
        total++;
        if (cause !== want_cause) begin
            bad++;
            $display("FAIL req_cause got=%b want=%b", cause, want_cause);
        end
    endtask

    task automatic test_sw_pulse();
        req_pulse(100, 1'b1, 1'b0, 2'b01);
    endtask

    task automatic test_both_req();
        req_pulse(200, 1'b1, 1'b1, 2'b10);
    endtask

    task automatic test_held_req_n1();
        sw_rst6 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (o_rstn6 !== 1'b0 || busy6 !== 1'b1) begin
                bad++;
                $display("FAIL held_req_n1 cycle=%0d got rstn=%b busy=%b want 0/1", i, o_rstn6, busy6);
            end
        end
        sw_rst6 = 1'b0;
        tick();
        total++;
        if (o_rstn6 !== 1'b0 || busy6 !== 1'b1) begin
            bad++;
            $display("FAIL held_last_plus1 got rstn=%b busy=%b want 0/1", o_rstn6, busy6);
        end
        tick();
        total++;
        if (o_rstn6 !== 1'b1 || busy6 !== 1'b0 || cause6 !== 2'b01) begin
            bad++;
            $display("FAIL held_last_plus2 got rstn=%b busy=%b cause=%b want 1/0/01", o_rstn6, busy6, cause6);
        end
        total++;
        if (o_rstn !== 4'hf || busy !== 1'b0) begin
            bad++;
            $display("FAIL other_dut_stable got rstn=%h busy=%b want f/0", o_rstn, busy);
        end
    endtask

    task automatic test_async_reassert();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (o_rstn !== 4'h0 || busy !== 1'b1 || cause !== 2'b00) begin
            bad++;
            $display("FAIL async_assert got rstn=%h busy=%b cause=%b want 0/1/00", o_rstn, busy, cause);
        end
        total++;
        if (o_rstn6 !== 1'b0 || busy6 !== 1'b1 || cause6 !== 2'b00) begin
            bad++;
            $display("FAIL async_assert_n1 got rstn=%b busy=%b cause=%b want 0/1/00", o_rstn6, busy6, cause6);
        end
        #1;
        rstn    = 1'b1;
        edge_no = 0;
    endtask

    task automatic test_wdt_mid_stagger();
        while (edge_no < 21) begin
            tick();
            total++;
            if (o_rstn !== exp_rstn(edge_no, 19) || busy !== exp_busy(edge_no, 19)) begin
                bad++;
                $display("FAIL replay_seq edge=%0d got rstn=%h busy=%b want rstn=%h busy=%b",
                         edge_no, o_rstn, busy, exp_rstn(edge_no, 19), exp_busy(edge_no, 19));
            end
            total++;
            if (o_rstn6 !== 1'(edge_no >= 5)) begin
                bad++;
                $display("FAIL replay_n1 edge=%0d got rstn=%b want %b", edge_no, o_rstn6, edge_no >= 5);
            end
        end
        wdt_rst = 1'b1;
        tick();
        wdt_rst = 1'b0;
        total++;
        if (o_rstn !== 4'h0 || busy !== 1'b1 || cause !== 2'b10) begin
            bad++;
            $display("FAIL wdt_mid_assert got rstn=%h busy=%b cause=%b want 0/1/10", o_rstn, busy, cause);
        end
        while (edge_no < 55) begin
            tick();
            total++;
            if (o_rstn !== exp_rstn(edge_no, 39) || busy !== exp_busy(edge_no, 39)) begin
                bad++;
                $display("FAIL wdt_mid_seq edge=%0d got rstn=%h busy=%b want rstn=%h busy=%b",
                         edge_no, o_rstn, busy, exp_rstn(edge_no, 39), exp_busy(edge_no, 39));
            end
        end
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        total    = 0;
        bad      = 0;
        edge_no  = 0;
        rstn     = 1'b0;
        sw_rst   = 1'b0;
        wdt_rst  = 1'b0;
        sw_rst6  = 1'b0;
        wdt_rst6 = 1'b0;

        test_reset();
        test_por();
        test_sw_pulse();
        test_both_req();
        test_held_req_n1();
        test_async_reassert();
        test_wdt_mid_stagger();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
